// File: rtl/small_reg_pkg.sv
// rtl/small_reg_pkg.sv - default parameter constants for small_reg_component
package small_reg_pkg;

   localparam int          DEFAULT_WIDTH       = 4;
   localparam int          MIN_WIDTH           = 1;
   localparam int          MAX_WIDTH           = 64;
   localparam logic [63:0] DEFAULT_RESET_VALUE = 64'd0;

endpackage : small_reg_pkg

// File: rtl/small_reg_component.sv
// rtl/small_reg_component.sv - WIDTH-bit load-enabled register with async active-low reset
//
// Ports:
//   clock  in   1      rising-edge clock
//   reset  in   1      asynchronous reset, active low (0 = held at RESET_VALUE)
//   write  in   1      load enable, active high
//   in     in   WIDTH  data to store
//   out    out  WIDTH  stored value, straight from the flop
module small_reg_component
   import small_reg_pkg::*;
#(
   parameter int               WIDTH       = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             write,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("small_reg_component: WIDTH=%0d outside legal range 1..64", WIDTH);
   end

   logic [WIDTH-1:0] value_q;

   // Reset is checked first so X/Z on write or in cannot leak in while reset is low.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         value_q <= RESET_VALUE;
      end else if (write) begin
         value_q <= in;
      end
   end

   assign out = value_q;

endmodule : small_reg_component

// File: tb/tb_small_reg_component.sv
// tb/tb_small_reg_component.sv - self-checking bench for small_reg_component
module tb_small_reg_component;

   localparam int         W    = 4;
   localparam logic [3:0] RSTV = 4'b0000;

   logic         clock;
   logic         reset;
   logic         write;
   logic [W-1:0] din;
   logic [W-1:0] dout;

   int n_cmp;
   int n_err;

   small_reg_component #(
      .WIDTH       (W),
      .RESET_VALUE (RSTV)
   ) dut (
      .clock (clock),
      .reset (reset),
      .write (write),
      .in    (din),
      .out   (dout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic       wr;
      logic [3:0] data;
      int         edges;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[12];

   // Reference: the register holds the most recent write accepted since the
   // last reset, or the reset value if there has been none.
   logic [W-1:0] accepted_q[$];

   function automatic logic [W-1:0] model_value();
      if (accepted_q.size() == 0) return RSTV;
      return accepted_q[$];
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;

      vecs[0]  = '{1'b0, 1'b0, 4'b0110, 2, 4'b0000};
      vecs[1]  = '{1'b0, 1'b0, 4'b0000, 1, 4'b0000};
      vecs[2]  = '{1'b1, 1'b1, 4'b1111, 1, 4'b1111};
      vecs[3]  = '{1'b0, 1'b0, 4'b0000, 1, 4'b0000};
      vecs[4]  = '{1'b1, 1'b0, 4'b1111, 1, 4'b0000};
      vecs[5]  = '{1'b1, 1'b1, 4'b1010, 1, 4'b1010};
      vecs[6]  = '{1'b1, 1'b0, 4'b0101, 3, 4'b1010};
      vecs[7]  = '{1'b0, 1'b1, 4'b1001, 2, 4'b0000};
      vecs[8]  = '{1'b1, 1'b1, 4'b1001, 1, 4'b1001};
      vecs[9]  = '{1'b1, 1'b1, 4'b0011, 1, 4'b0011};
      vecs[10] = '{1'b1, 1'b1, 4'b1100, 1, 4'b1100};
      vecs[11] = '{1'b1, 1'b0, 4'b0000, 2, 4'b1100};

      reset = 1'b0;
      write = 1'b0;
      din   = 4'b0000;
      #2;
      check("reset_state", dout, RSTV);

      for (int i = 0; i < 12; i++) begin
         reset = vecs[i].rst;
         write = vecs[i].wr;
         din   = vecs[i].data;
         #1;
         repeat (vecs[i].edges) @(posedge clock);
         #1;
         check($sformatf("vec%0d", i), dout, vecs[i].exp);
      end

      // Mid-cycle reset: load 1111, then drop reset with no clock edge.
      reset = 1'b1;
      write = 1'b1;
      din   = 4'b1111;
      @(posedge clock);
      #1;
      check("mid_load", dout, 4'b1111);
      write = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("mid_async_reset", dout, 4'b0000);
      repeat (2) @(posedge clock);
      #1;
      check("reset_holds_clocked", dout, 4'b0000);

      // X/Z on write and in during reset must be ignored.
      write = 1'bx;
      din   = 4'bxz10;
      repeat (2) @(posedge clock);
      #1;
      check("reset_ignores_x", dout, 4'b0000);

      // Release with write low: register keeps the reset value until a write.
      reset = 1'b1;
      write = 1'b0;
      din   = 4'b0111;
      @(posedge clock);
      #1;
      check("post_reset_hold", dout, 4'b0000);

      // Randomized run against the reference model.
      accepted_q.delete();
      reset = 1'b0;
      #1;
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 9) != 0);
         write = $urandom_range(0, 1);
         din   = W'($urandom);
         #1;
         if (!reset) begin
            accepted_q.delete();
            check("rnd_async", dout, model_value());
         end
         @(posedge clock);
         if (reset && write) accepted_q.push_back(din);
         #1;
         check("rnd_edge", dout, model_value());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_small_reg_component
